// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - out-of-order ALU issue queue with age-matrix oldest-ready select
// Entries wait for both source tags, then the oldest ready ops are registered onto the ALU ports.
module alu_issue_sched #(
   parameter int NENT       = 8,
   parameter int LNENT      = 3,
   parameter int NALU       = 2,
   parameter int NWB        = 2,
   parameter int CNTRL_SIZE = 7,
   parameter int NCOMMIT    = 32,
   parameter int LNCOMMIT   = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CNTRL_SIZE-1:0]        in_control,
   input  logic [LNCOMMIT-1:0]          in_rd,
   input  logic                         in_makes_rd,
   input  logic                         in_needs_rs2,
   input  logic [LNCOMMIT-1:0]          in_rs1,
   input  logic [LNCOMMIT-1:0]          in_rs2,
   input  logic                         in_rs1_rdy,
   input  logic                         in_rs2_rdy,
   input  logic [NWB-1:0]               wb_valid,
   input  logic [NWB*LNCOMMIT-1:0]      wb_rd,
   input  logic [NCOMMIT-1:0]           commit_kill,
   output logic [NALU-1:0]              iss_valid,
   output logic [NALU*CNTRL_SIZE-1:0]   iss_control,
   output logic [NALU*LNCOMMIT-1:0]     iss_rd,
   output logic [NALU*LNCOMMIT-1:0]     iss_rs1,
   output logic [NALU*LNCOMMIT-1:0]     iss_rs2,
   output logic [NALU-1:0]              iss_makes_rd,
   output logic [NALU-1:0]              iss_needs_rs2,
   output logic [LNENT:0]               occupancy
);

   logic [NENT-1:0]       r_valid, r_rs1_rdy, r_rs2_rdy, r_makes_rd, r_needs_rs2;
   logic [CNTRL_SIZE-1:0] r_control [NENT];
   logic [LNCOMMIT-1:0]   r_rd [NENT];
   logic [LNCOMMIT-1:0]   r_rs1 [NENT];
   logic [LNCOMMIT-1:0]   r_rs2 [NENT];
   logic [NENT-1:0]       r_old [NENT];

   logic [NALU-1:0]            r_iss_valid, r_iss_makes_rd, r_iss_needs_rs2;
   logic [NALU*CNTRL_SIZE-1:0] r_iss_control;
   logic [NALU*LNCOMMIT-1:0]   r_iss_rd, r_iss_rs1, r_iss_rs2;
   logic [LNENT:0]             r_occ;

   logic [NENT-1:0]       w_ready, w_kill, w_wake1, w_wake2, w_alloc, w_issued, w_avail;
   logic [NENT-1:0]       w_col [NENT];
   logic [NENT-1:0]       w_pick [NALU];
   logic                  w_in_wake1, w_in_wake2, w_accept, w_found;
   logic [LNENT:0]        w_n_iss, w_n_kill;
   logic [CNTRL_SIZE-1:0] w_sel_ctrl [NALU];
   logic [LNCOMMIT-1:0]   w_sel_rd [NALU];
   logic [LNCOMMIT-1:0]   w_sel_rs1 [NALU];
   logic [LNCOMMIT-1:0]   w_sel_rs2 [NALU];
   logic [NALU-1:0]       w_sel_mrd, w_sel_nrs2;

   assign in_ready = ~(&r_valid);
   assign w_accept = in_valid & in_ready & ~commit_kill[in_rd];

   always_comb begin
      w_ready = '0;
      w_kill  = '0;
      w_wake1 = '0;
      w_wake2 = '0;
      w_in_wake1 = 1'b0;
      w_in_wake2 = 1'b0;
      for (int b = 0; b < NWB; b++) begin
         if (wb_valid[b] && wb_rd[b*LNCOMMIT +: LNCOMMIT] == in_rs1) w_in_wake1 = 1'b1;
         if (wb_valid[b] && wb_rd[b*LNCOMMIT +: LNCOMMIT] == in_rs2) w_in_wake2 = 1'b1;
      end
      for (int i = 0; i < NENT; i++) begin
         w_kill[i]  = r_valid[i] & commit_kill[r_rd[i]];
         w_ready[i] = r_valid[i] & r_rs1_rdy[i] & r_rs2_rdy[i] & ~commit_kill[r_rd[i]];
         for (int b = 0; b < NWB; b++) begin
            if (wb_valid[b] && wb_rd[b*LNCOMMIT +: LNCOMMIT] == r_rs1[i]) w_wake1[i] = r_valid[i];
            if (wb_valid[b] && wb_rd[b*LNCOMMIT +: LNCOMMIT] == r_rs2[i]) w_wake2[i] = r_valid[i];
         end
      end
   end

   // w_col[i][j] = entry j is older than entry i
   always_comb begin
      w_col = '{default: '0};
      for (int i = 0; i < NENT; i++)
         for (int j = 0; j < NENT; j++)
            w_col[i][j] = r_old[j][i];
   end

   // Each ALU takes the ready entry that no other remaining ready entry is older than
   always_comb begin
      w_avail  = w_ready;
      w_issued = '0;
      w_pick   = '{default: '0};
      for (int a = 0; a < NALU; a++) begin
         for (int i = 0; i < NENT; i++)
            w_pick[a][i] = w_avail[i] & ~(|(w_avail & w_col[i]));
         w_avail  = w_avail & ~w_pick[a];
         w_issued = w_issued | w_pick[a];
      end
   end

   always_comb begin
      w_sel_ctrl = '{default: '0};
      w_sel_rd   = '{default: '0};
      w_sel_rs1  = '{default: '0};
      w_sel_rs2  = '{default: '0};
      w_sel_mrd  = '0;
      w_sel_nrs2 = '0;
      for (int a = 0; a < NALU; a++)
         for (int i = 0; i < NENT; i++)
            if (w_pick[a][i]) begin
               w_sel_ctrl[a] = w_sel_ctrl[a] | r_control[i];
               w_sel_rd[a]   = w_sel_rd[a]   | r_rd[i];
               w_sel_rs1[a]  = w_sel_rs1[a]  | r_rs1[i];
               w_sel_rs2[a]  = w_sel_rs2[a]  | r_rs2[i];
               w_sel_mrd[a]  = w_sel_mrd[a]  | r_makes_rd[i];
               w_sel_nrs2[a] = w_sel_nrs2[a] | r_needs_rs2[i];
            end
   end

   always_comb begin
      w_alloc  = '0;
      w_found  = 1'b0;
      w_n_iss  = '0;
      w_n_kill = '0;
      for (int i = 0; i < NENT; i++) begin
         if (!r_valid[i] && !w_found) begin
            w_alloc[i] = w_accept;
            w_found    = 1'b1;
         end
         w_n_iss  = w_n_iss  + (LNENT+1)'(w_issued[i]);
         w_n_kill = w_n_kill + (LNENT+1)'(w_kill[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid         <= '0;
         r_rs1_rdy       <= '0;
         r_rs2_rdy       <= '0;
         r_old           <= '{default: '0};
         r_iss_valid     <= '0;
         r_iss_control   <= '0;
         r_iss_rd        <= '0;
         r_iss_rs1       <= '0;
         r_iss_rs2       <= '0;
         r_iss_makes_rd  <= '0;
         r_iss_needs_rs2 <= '0;
         r_occ           <= '0;
      end else begin
         for (int i = 0; i < NENT; i++) begin
            r_valid[i] <= (r_valid[i] & ~w_issued[i] & ~w_kill[i]) | w_alloc[i];
            if (w_alloc[i]) begin
               r_rs1_rdy[i] <= in_rs1_rdy | w_in_wake1;
               r_rs2_rdy[i] <= in_rs2_rdy | ~in_needs_rs2 | w_in_wake2;
               r_old[i]     <= '0;
            end else begin
               if (w_wake1[i]) r_rs1_rdy[i] <= 1'b1;
               if (w_wake2[i]) r_rs2_rdy[i] <= 1'b1;
               for (int j = 0; j < NENT; j++)
                  if (w_alloc[j]) r_old[i][j] <= r_valid[i];
            end
         end
         for (int a = 0; a < NALU; a++) begin
            r_iss_valid[a] <= |w_pick[a];
            if (|w_pick[a]) begin
               r_iss_control[a*CNTRL_SIZE +: CNTRL_SIZE] <= w_sel_ctrl[a];
               r_iss_rd[a*LNCOMMIT +: LNCOMMIT]          <= w_sel_rd[a];
               r_iss_rs1[a*LNCOMMIT +: LNCOMMIT]         <= w_sel_rs1[a];
               r_iss_rs2[a*LNCOMMIT +: LNCOMMIT]         <= w_sel_rs2[a];
               r_iss_makes_rd[a]                         <= w_sel_mrd[a];
               r_iss_needs_rs2[a]                        <= w_sel_nrs2[a];
            end
         end
         r_occ <= r_occ + (LNENT+1)'(w_accept) - w_n_iss - w_n_kill;
      end
   end

   // Payload needs no reset: it is only observed while the matching valid bit is set
   always_ff @(posedge clk) begin
      for (int i = 0; i < NENT; i++)
         if (w_alloc[i]) begin
            r_control[i]   <= in_control;
            r_rd[i]        <= in_rd;
            r_rs1[i]       <= in_rs1;
            r_rs2[i]       <= in_rs2;
            r_makes_rd[i]  <= in_makes_rd;
            r_needs_rs2[i] <= in_needs_rs2;
         end
   end

   assign iss_valid     = r_iss_valid;
   assign iss_control   = r_iss_control;
   assign iss_rd        = r_iss_rd;
   assign iss_rs1       = r_iss_rs1;
   assign iss_rs2       = r_iss_rs2;
   assign iss_makes_rd  = r_iss_makes_rd;
   assign iss_needs_rs2 = r_iss_needs_rs2;
   assign occupancy     = r_occ;

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - directed self-checking bench for alu_issue_sched
module tb_alu_issue_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [6:0]  in_control;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic        in_makes_rd, in_needs_rs2, in_rs1_rdy, in_rs2_rdy;
   logic [1:0]  wb_valid;
   logic [9:0]  wb_rd;
   logic [31:0] commit_kill;
   logic [1:0]  iss_valid, iss_makes_rd, iss_needs_rs2;
   logic [13:0] iss_control;
   logic [9:0]  iss_rd, iss_rs1, iss_rs2;
   logic [3:0]  occupancy;

   int errors = 0;
   int checks = 0;

   alu_issue_sched dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_control(in_control), .in_rd(in_rd),
      .in_makes_rd(in_makes_rd), .in_needs_rs2(in_needs_rs2), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .commit_kill(commit_kill), .iss_valid(iss_valid), .iss_control(iss_control),
      .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_makes_rd(iss_makes_rd),
      .iss_needs_rs2(iss_needs_rs2), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic drive_op(input logic [4:0] rd, input logic [4:0] rs1, input logic r1,
                           input logic [4:0] rs2, input logic r2, input logic nrs2);
      in_valid     = 1'b1;
      in_control   = {2'b00, rd} + 7'd1;
      in_rd        = rd;
      in_makes_rd  = 1'b1;
      in_needs_rs2 = nrs2;
      in_rs1       = rs1;
      in_rs1_rdy   = r1;
      in_rs2       = rs2;
      in_rs2_rdy   = r2;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_rs1_rdy = 1'b0;
      in_rs2_rdy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      in_control = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_makes_rd = 1'b0; in_needs_rs2 = 1'b0;
      wb_valid = '0; wb_rd = '0; commit_kill = '0;
      #3;
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL rst_iss_valid got %b exp 00", iss_valid); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      checks++; if (iss_rd !== 10'd0) begin errors++; $display("FAIL rst_iss_rd got %h exp 0", iss_rd); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk); drive_op(5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
      @(negedge clk); idle();
      checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL t1_occ1 got %0d exp 1", occupancy); end
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL t1_early got %b exp 00", iss_valid); end
      @(negedge clk);
      checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL t1_iss_valid got %b exp 01", iss_valid); end
      checks++; if (iss_rd[4:0] !== 5'd3) begin errors++; $display("FAIL t1_rd got %0d exp 3", iss_rd[4:0]); end
      checks++; if (iss_control[6:0] !== 7'd4) begin errors++; $display("FAIL t1_ctrl got %0d exp 4", iss_control[6:0]); end
      checks++; if (iss_rs1[4:0] !== 5'd1 || iss_rs2[4:0] !== 5'd2) begin errors++; $display("FAIL t1_srcs got %0d/%0d exp 1/2", iss_rs1[4:0], iss_rs2[4:0]); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL t1_occ0 got %0d exp 0", occupancy); end
   endtask

   task automatic test_wakeup_order();
      @(negedge clk); drive_op(5'd4, 5'd9, 1'b0, 5'd2, 1'b1, 1'b1);
      @(negedge clk); drive_op(5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
      @(negedge clk); idle();
      @(negedge clk);
      checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL t2_b_valid got %b exp 01", iss_valid); end
      checks++; if (iss_rd[4:0] !== 5'd5) begin errors++; $display("FAIL t2_b_rd got %0d exp 5", iss_rd[4:0]); end
      checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL t2_occ got %0d exp 1", occupancy); end
      wb_valid = 2'b01; wb_rd = {5'd0, 5'd9};
      @(negedge clk); wb_valid = 2'b00;
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL t2_gap got %b exp 00", iss_valid); end
      @(negedge clk);
      checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL t2_a_valid got %b exp 01", iss_valid); end
      checks++; if (iss_rd[4:0] !== 5'd4) begin errors++; $display("FAIL t2_a_rd got %0d exp 4", iss_rd[4:0]); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL t2_occ0 got %0d exp 0", occupancy); end
   endtask

   task automatic test_fill_drain();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); drive_op(5'(16 + k), 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
      end
      @(negedge clk); idle();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t3_full_ready got %b exp 0", in_ready); end
      checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL t3_occ8 got %0d exp 8", occupancy); end
      wb_valid = 2'b01; wb_rd = {5'd0, 5'd7};
      @(negedge clk); wb_valid = 2'b00;
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL t3_gap got %b exp 00", iss_valid); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL t3_valid%0d got %b exp 11", c, iss_valid); end
         checks++; if (iss_rd[4:0] !== 5'(16 + 2*c)) begin errors++; $display("FAIL t3_rd0_%0d got %0d exp %0d", c, iss_rd[4:0], 16 + 2*c); end
         checks++; if (iss_rd[9:5] !== 5'(17 + 2*c)) begin errors++; $display("FAIL t3_rd1_%0d got %0d exp %0d", c, iss_rd[9:5], 17 + 2*c); end
         checks++; if (iss_needs_rs2 !== 2'b00) begin errors++; $display("FAIL t3_nrs2_%0d got %b exp 00", c, iss_needs_rs2); end
      end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL t3_occ0 got %0d exp 0", occupancy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t3_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_same_cycle_wakeup();
      @(negedge clk); drive_op(5'd13, 5'd6, 1'b0, 5'd2, 1'b1, 1'b1);
      wb_valid = 2'b10; wb_rd = {5'd6, 5'd0};
      @(negedge clk); idle(); wb_valid = 2'b00;
      checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL t4_occ1 got %0d exp 1", occupancy); end
      @(negedge clk);
      checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL t4_valid got %b exp 01", iss_valid); end
      checks++; if (iss_rd[4:0] !== 5'd13) begin errors++; $display("FAIL t4_rd got %0d exp 13", iss_rd[4:0]); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL t4_occ0 got %0d exp 0", occupancy); end
   endtask

   task automatic test_kill();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive_op(5'(10 + k), 5'd25, 1'b0, 5'd2, 1'b1, 1'b1);
      end
      @(negedge clk); idle();
      commit_kill = 32'h0000_0800;
      wb_valid = 2'b01; wb_rd = {5'd0, 5'd25};
      @(negedge clk); wb_valid = 2'b00;
      checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL t5_occ2 got %0d exp 2", occupancy); end
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL t5_gap got %b exp 00", iss_valid); end
      @(negedge clk);
      checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL t5_valid got %b exp 11", iss_valid); end
      checks++; if (iss_rd[4:0] !== 5'd10) begin errors++; $display("FAIL t5_rd0 got %0d exp 10", iss_rd[4:0]); end
      checks++; if (iss_rd[9:5] !== 5'd12) begin errors++; $display("FAIL t5_rd1 got %0d exp 12", iss_rd[9:5]); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL t5_occ0 got %0d exp 0", occupancy); end
      commit_kill = '0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL b2b_valid%0d got %b exp 01", i, iss_valid); end
            checks++; if (iss_rd[4:0] !== 5'(20 + i - 2)) begin errors++; $display("FAIL b2b_rd%0d got %0d exp %0d", i, iss_rd[4:0], 20 + i - 2); end
         end
         if (i < 4) drive_op(5'(20 + i), 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
         else idle();
      end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL b2b_occ got %0d exp 0", occupancy); end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); drive_op(5'(1 + k), 5'd30, 1'b0, 5'd2, 1'b1, 1'b1);
      end
      @(negedge clk); idle();
      wb_valid = 2'b01; wb_rd = {5'd0, 5'd30};
      @(negedge clk); wb_valid = 2'b00;
      @(negedge clk);
      checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL t6_occ5 got %0d exp 5", occupancy); end
      checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL t6_pre_valid got %b exp 11", iss_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL t6_valid got %b exp 00", iss_valid); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL t6_occ got %0d exp 0", occupancy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t6_ready got %b exp 1", in_ready); end
      checks++; if (iss_rd !== 10'd0 || iss_control !== 14'd0) begin errors++; $display("FAIL t6_payload got %h/%h exp 0/0", iss_rd, iss_control); end
      @(negedge clk); reset = 1'b0;
      drive_op(5'd2, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
      @(negedge clk); idle();
      @(negedge clk);
      checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL t6_post_valid got %b exp 01", iss_valid); end
      checks++; if (iss_rd[4:0] !== 5'd2) begin errors++; $display("FAIL t6_post_rd got %0d exp 2", iss_rd[4:0]); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL t6_post_occ got %0d exp 0", occupancy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_wakeup_order();
      test_fill_drain();
      test_same_cycle_wakeup();
      test_kill();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
